// File: rtl/ps2_rx_scan_decoder.sv
// PS/2 keyboard receiver: deglitched clock, 11-bit frame capture with timeout,
// E0/F0 prefix decoding into make/break events, buffered in a valid/ready FIFO.
module ps2_rx_scan_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned FIFO_AW        = 2,
  parameter int unsigned EVENT_MODE     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       clr_ovf,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       rx_byte_tick,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PTR_W = FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } evt_t;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic                  ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_q, filt_next_c, fall_edge_c;

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [8:0]            shreg_q, shreg_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  tick_d, err_d;
  logic [7:0]            rx_byte_d;

  logic                  ext_q, ext_d, brk_q, brk_d, push_c;
  evt_t                  push_evt_c;

  evt_t                  mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  full_c, pop_c, wr_en_c, drop_c;
  evt_t                  head_c;

  // Two-flop synchronisers and ps2c majority-free all-ones/all-zeros filter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2c_s1 <= 1'b1;
      ps2c_s2 <= 1'b1;
      ps2d_s1 <= 1'b1;
      ps2d_s2 <= 1'b1;
      filt_sr <= '1;
      filt_q  <= 1'b1;
    end else begin
      ps2c_s1 <= ps2c;
      ps2c_s2 <= ps2c_s1;
      ps2d_s1 <= ps2d;
      ps2d_s2 <= ps2d_s1;
      filt_sr <= {filt_sr[FILTER_LEN-2:0], ps2c_s2};
      filt_q  <= filt_next_c;
    end
  end

  always_comb begin
    filt_next_c = filt_q;
    if (&filt_sr)       filt_next_c = 1'b1;
    else if (~|filt_sr) filt_next_c = 1'b0;
    fall_edge_c = filt_q & ~filt_next_c;
  end

  // Frame FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      tmo_q        <= '0;
      rx_byte_tick <= 1'b0;
      frame_err    <= 1'b0;
      rx_byte      <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      tmo_q        <= tmo_d;
      rx_byte_tick <= tick_d;
      frame_err    <= err_d;
      rx_byte      <= rx_byte_d;
    end
  end

  // Stop bit is judged as it arrives so the tick is visible during CHECK
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = tmo_q;
    tick_d    = 1'b0;
    err_d     = 1'b0;
    rx_byte_d = rx_byte;
    case (state_q)
      S_IDLE: begin
        if (fall_edge_c && !ps2d_s2) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      end
      S_SHIFT: begin
        if (fall_edge_c) begin
          tmo_d = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = S_CHECK;
            if ((^shreg_q) && ps2d_s2) begin
              tick_d    = 1'b1;
              rx_byte_d = shreg_q[7:0];
            end else begin
              err_d = 1'b1;
            end
          end else begin
            shreg_d   = {ps2d_s2, shreg_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Prefix decoder: E0/F0 only arm flags; any other byte emits and clears them
  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    push_c     = 1'b0;
    push_evt_c = '{code: rx_byte, brk: brk_q, ext: ext_q};
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_byte_tick) begin
      if (rx_byte == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == CODE_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (EVENT_MODE == 0)      push_c = brk_q;
        else if (EVENT_MODE == 1) push_c = ~brk_q;
        else                      push_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  // Event FIFO; a pop frees the slot for a simultaneous push when full
  always_comb begin
    evt_valid = (wr_ptr != rd_ptr);
    full_c    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    pop_c     = evt_valid & evt_ready;
    wr_en_c   = push_c & (~full_c | pop_c);
    drop_c    = push_c & full_c & ~pop_c;
    head_c    = evt_valid ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
    evt_code  = head_c.code;
    evt_break = head_c.brk;
    evt_ext   = head_c.ext;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr[FIFO_AW-1:0]] <= push_evt_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop_c)       overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_scan_decoder.sv
// Bench for ps2_rx_scan_decoder: mode-2 and mode-0 instances driven by the same
// PS/2 frames, events compared against a queue-based prefix/FIFO model.
module tb_ps2_rx_scan_decoder;

  localparam int unsigned FL    = 8;
  localparam int unsigned TMO   = 400;
  localparam int unsigned AW    = 2;
  localparam int          DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset, ps2d, ps2c, clr_ovf, evt_ready;

  logic       v2, b2, e2, tick2, err2, ovf2;
  logic [7:0] c2, rxb2;
  logic       v0, b0, e0, tick0, err0, ovf0;
  logic [7:0] c0, rxb0;

  ps2_rx_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_AW(AW), .EVENT_MODE(2)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .clr_ovf(clr_ovf),
    .evt_ready(evt_ready), .evt_valid(v2), .evt_code(c2), .evt_break(b2), .evt_ext(e2),
    .rx_byte_tick(tick2), .rx_byte(rxb2), .frame_err(err2), .overflow(ovf2));

  ps2_rx_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_AW(AW), .EVENT_MODE(0)) dut_m0 (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .clr_ovf(clr_ovf),
    .evt_ready(evt_ready), .evt_valid(v0), .evt_code(c0), .evt_break(b0), .evt_ext(e0),
    .rx_byte_tick(tick0), .rx_byte(rxb0), .frame_err(err0), .overflow(ovf0));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int nticks = 0, nerrs = 0, npop2 = 0, npop0 = 0;
  logic [9:0] q2[$], q0[$];
  logic [9:0] h2, h0;
  logic ext_p = 1'b0, brk_p = 1'b0;
  logic xovf2 = 1'b0, xovf0 = 1'b0;
  logic [7:0] xrx = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Head events are checked against the model on every accepted handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (tick2) nticks++;
      if (err2) nerrs++;
      if (v2 && evt_ready) begin
        if (q2.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL dut2_spurious_evt: observed %0h expected none", {c2, b2, e2});
        end else begin
          h2 = q2.pop_front();
          check("dut2_evt", 32'({c2, b2, e2}), 32'(h2));
          npop2++;
        end
      end
      if (v0 && evt_ready) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL dut0_spurious_evt: observed %0h expected none", {c0, b0, e0});
        end else begin
          h0 = q0.pop_front();
          check("dut0_evt", 32'({c0, b0, e0}), 32'(h0));
          npop0++;
        end
      end
    end
  end

  task automatic push_model(input logic [9:0] ev, input bit mode0);
    if (!mode0) begin
      if (!evt_ready && q2.size() >= DEPTH) xovf2 = 1'b1;
      else q2.push_back(ev);
    end else begin
      if (!evt_ready && q0.size() >= DEPTH) xovf0 = 1'b1;
      else q0.push_back(ev);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [9:0] ev;
    xrx = b;
    if (b == 8'hE0) ext_p = 1'b1;
    else if (b == 8'hF0) brk_p = 1'b1;
    else begin
      ev = {b, brk_p, ext_p};
      push_model(ev, 1'b0);
      if (brk_p) push_model(ev, 1'b1);
      ext_p = 1'b0;
      brk_p = 1'b0;
    end
  endtask

  task automatic model_err();
    ext_p = 1'b0;
    brk_p = 1'b0;
  endtask

  // Data changes while ps2c is high; sender holds each level for 'half' clk cycles
  task automatic send_bits(input logic [10:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      tick(half);
      ps2c = 1'b0;
      tick(half);
      ps2c = 1'b1;
    end
    tick(half);
    ps2d = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
    logic par;
    par = (~^b) ^ bad_par;
    if (!bad_par && !bad_stop) model_byte(b);
    else model_err();
    send_bits({~bad_stop, par, b, 1'b0}, 11, half);
    tick(30);
  endtask

  initial begin
    int t0, r0, p0;
    int xt, xe;
    logic [7:0] rb;
    bit bp, bs;
    int half;

    reset = 1'b1; ps2d = 1'b1; ps2c = 1'b1; clr_ovf = 1'b0; evt_ready = 1'b1;
    tick(5);
    check("rst_evt_valid", 32'(v2), 32'(0));
    check("rst_evt_head", 32'({c2, b2, e2}), 32'(0));
    check("rst_rx_byte", 32'(rxb2), 32'(0));
    check("rst_pulses", 32'({tick2, err2}), 32'(0));
    check("rst_overflow", 32'(ovf2), 32'(0));
    check("rst_dut0_valid", 32'(v0), 32'(0));
    reset = 1'b0;
    tick(5);

    // Make then break of 1C
    t0 = nticks; r0 = nerrs; p0 = npop0;
    send_frame(8'h1C, 0, 0, 20);
    send_frame(8'hF0, 0, 0, 20);
    send_frame(8'h1C, 0, 0, 20);
    check("s1_ticks", 32'(nticks - t0), 32'(3));
    check("s1_errs", 32'(nerrs - r0), 32'(0));
    check("s1_drained", 32'(q2.size()), 32'(0));
    check("s1_mode0_evts", 32'(npop0 - p0), 32'(1));
    check("s1_rx_byte", 32'(rxb2), 32'(xrx));

    // Extended make and break of 75
    t0 = nticks;
    send_frame(8'hE0, 0, 0, 20);
    send_frame(8'h75, 0, 0, 20);
    send_frame(8'hE0, 0, 0, 20);
    send_frame(8'hF0, 0, 0, 20);
    send_frame(8'h75, 0, 0, 20);
    check("s2_ticks", 32'(nticks - t0), 32'(5));
    check("s2_drained", 32'(q2.size() + q0.size()), 32'(0));

    // Bad parity and bad stop; the pending F0 must be discarded by the errors
    send_frame(8'hF0, 0, 0, 20);
    t0 = nticks; r0 = nerrs;
    send_frame(8'h1C, 1, 0, 20);
    send_frame(8'h2A, 0, 1, 20);
    check("s3_errs", 32'(nerrs - r0), 32'(2));
    check("s3_ticks", 32'(nticks - t0), 32'(0));
    check("s3_rx_byte_held", 32'(rxb2), 32'(8'hF0));
    check("s3_no_evt", 32'(v2), 32'(0));
    send_frame(8'h1C, 0, 0, 20);
    check("s3_drained", 32'(q2.size() + q0.size()), 32'(0));

    // Stalled frame times out, then the next frame is clean
    t0 = nticks; r0 = nerrs;
    model_err();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5, 20);
    tick(TMO + 50);
    check("s4_timeout_err", 32'(nerrs - r0), 32'(1));
    check("s4_timeout_ticks", 32'(nticks - t0), 32'(0));
    send_frame(8'h2A, 0, 0, 20);
    check("s4_rx_byte", 32'(rxb2), 32'(8'h2A));
    check("s4_ticks", 32'(nticks - t0), 32'(1));
    check("s4_drained", 32'(q2.size()), 32'(0));

    // FIFO overflow with the consumer stalled, then drain and clear
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 0, 0, 20);
    check("s5_valid", 32'(v2), 32'(1));
    check("s5_overflow", 32'(ovf2), 32'(xovf2));
    check("s5_head", 32'({c2, b2, e2}), 32'({8'h10, 2'b00}));
    p0 = npop2;
    evt_ready = 1'b1;
    tick(20);
    check("s5_drain_count", 32'(npop2 - p0), 32'(DEPTH));
    check("s5_empty", 32'(v2), 32'(0));
    check("s5_ovf_sticky", 32'(ovf2), 32'(1));
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    xovf2 = 1'b0;
    tick(1);
    check("s5_ovf_cleared", 32'(ovf2), 32'(xovf2));
    check("s5_mode0_ovf", 32'(ovf0), 32'(xovf0));

    // Three-sample ps2c glitch with data low must not start a frame
    t0 = nticks; r0 = nerrs;
    ps2d = 1'b0; ps2c = 1'b0;
    tick(3);
    ps2c = 1'b1;
    tick(40);
    ps2d = 1'b1;
    tick(TMO + 20);
    check("s6_glitch_pulses", 32'((nticks - t0) + (nerrs - r0)), 32'(0));
    send_frame(8'h5A, 0, 0, 20);
    check("s6_rx_byte", 32'(rxb2), 32'(8'h5A));
    check("s6_ticks", 32'(nticks - t0), 32'(1));

    // Randomised byte stream with prefixes, corrupted frames and jittered timing
    t0 = nticks; r0 = nerrs; xt = 0; xe = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rb = 8'hE0;
        2, 3:    rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 9) == 0);
      half = int'($urandom_range(16, 24));
      send_frame(rb, bp, bs, half);
      if (bp || bs) xe++;
      else xt++;
    end
    check("rnd_ticks", 32'(nticks - t0), 32'(xt));
    check("rnd_errs", 32'(nerrs - r0), 32'(xe));
    check("rnd_drained2", 32'(q2.size()), 32'(0));
    check("rnd_drained0", 32'(q0.size()), 32'(0));
    check("rnd_rx_byte", 32'(rxb2), 32'(xrx));
    check("rnd_overflow", 32'({ovf2, ovf0}), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
